// File: rtl/gate_sweep_checker_pkg.sv
// Shared definitions for the gate sweep checker: gate codes, FSM states,
// reference truth tables and a small priority helper.
package gate_sweep_checker_pkg;

    // Gate selection codes; 6 and 7 are unused and rejected.
    localparam logic [2:0] GateAnd  = 3'd0;
    localparam logic [2:0] GateOr   = 3'd1;
    localparam logic [2:0] GateNand = 3'd2;
    localparam logic [2:0] GateNor  = 3'd3;
    localparam logic [2:0] GateXor  = 3'd4;
    localparam logic [2:0] GateXnor = 3'd5;

    // Expected truth tables, bit k = output for input index {a,b} = k.
    // Packed so that ExpTt[code] selects the table for that gate code.
    localparam logic [5:0][3:0] ExpTt = {
        4'b1001,  // XNOR
        4'b0110,  // XOR
        4'b0001,  // NOR
        4'b0111,  // NAND
        4'b1110,  // OR
        4'b1000   // AND
    };

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSample,
        StCheck,
        StDone
    } state_e;

    // Index of the lowest set bit; only meaningful when diff is non-zero.
    function automatic logic [1:0] lowest_set(input logic [3:0] diff);
        if (diff[0]) begin
            return 2'd0;
        end else if (diff[1]) begin
            return 2'd1;
        end else if (diff[2]) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

endpackage

// File: rtl/gate_sweep_checker_gate_ref_lut.sv
// Reference lookup: maps a gate code to its expected truth table and flags
// whether the code names a supported gate.
module gate_ref_lut
    import gate_sweep_checker_pkg::*;
(
    input  logic [2:0] gate_sel,
    output logic [3:0] exp_tt,
    output logic       valid
);

    // Decode the gate code into its reference table.
    always_comb begin
        exp_tt = 4'b0000;
        valid  = 1'b0;
        if (gate_sel <= GateXnor) begin
            exp_tt = ExpTt[gate_sel];
            valid  = 1'b1;
        end
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps all four {a,b} input combinations into an external 2-input gate,
// captures its truth table and compares it against the selected reference.
module gate_sweep_checker
    import gate_sweep_checker_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] gate_sel,
    output logic       a,
    output logic       b,
    input  logic       gate_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] tt,
    output logic       pass,
    output logic       fail,
    output logic       bad_sel,
    output logic [1:0] err_idx
);

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYC - 1);

    state_e     state_q;
    logic [2:0] sel_q;
    logic [1:0] idx_q;
    logic [3:0] cnt_q;

    logic [2:0] lut_sel;
    logic [3:0] lut_tt;
    logic       lut_valid;

    // In IDLE the live request is validated; afterwards the latched code
    // supplies the reference table, so later gate_sel changes are ignored.
    assign lut_sel = (state_q == StIdle) ? gate_sel : sel_q;

    gate_ref_lut u_gate_ref_lut (
        .gate_sel (lut_sel),
        .exp_tt   (lut_tt),
        .valid    (lut_valid)
    );

    // Sweep FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= 3'd0;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a       <= 1'b0;
            b       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            tt      <= 4'b0000;
            pass    <= 1'b0;
            fail    <= 1'b0;
            bad_sel <= 1'b0;
            err_idx <= 2'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        tt      <= 4'b0000;
                        pass    <= 1'b0;
                        err_idx <= 2'd0;
                        busy    <= 1'b1;
                        if (lut_valid) begin
                            sel_q   <= gate_sel;
                            idx_q   <= 2'd0;
                            cnt_q   <= 4'd0;
                            a       <= 1'b0;
                            b       <= 1'b0;
                            fail    <= 1'b0;
                            bad_sel <= 1'b0;
                            state_q <= StDrive;
                        end else begin
                            // Unsupported gate: report immediately, no stimulus.
                            fail    <= 1'b1;
                            bad_sel <= 1'b1;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDrive: begin
                    if (cnt_q == SettleLast) begin
                        cnt_q   <= 4'd0;
                        state_q <= StSample;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StSample: begin
                    tt[idx_q] <= gate_in;
                    if (idx_q != 2'd3) begin
                        idx_q   <= idx_q + 2'd1;
                        {a, b}  <= idx_q + 2'd1;
                        state_q <= StDrive;
                    end else begin
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (tt == lut_tt) begin
                        pass    <= 1'b1;
                        fail    <= 1'b0;
                        err_idx <= 2'd0;
                    end else begin
                        pass    <= 1'b0;
                        fail    <= 1'b1;
                        err_idx <= lowest_set(tt ^ lut_tt);
                    end
                    idx_q   <= 2'd0;
                    a       <= 1'b0;
                    b       <= 1'b0;
                    done    <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2, the number of cycles each input combination is held before sampling; legal range 1..15.
REQ-002 SHALL have ports clk (input, 1): the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst (input, 1): asynchronous, active-high reset.
REQ-004 SHALL have port start (input, 1): request a sweep; sampled only in IDLE.
REQ-005 SHALL have port gate_sel (input, 3): expected gate. 0=AND, 1=OR, 2=NAND, 3=NOR, 4=XOR, 5=XNOR; 6 and 7 are invalid.
REQ-006 SHALL have ports a and b (output, 1 each): registered stimulus to the gate under test; index = {a,b}.
REQ-007 SHALL have port gate_in (input, 1): the observed gate output, driven combinationally from a and b.
REQ-008 SHALL have ports busy (output, 1) and done (output, 1): done is a one-cycle completion pulse.
REQ-009 SHALL have port tt (output, 4): captured truth table; bit k = gate_in observed at index k.
REQ-010 SHALL have ports pass, fail, bad_sel (output, 1 each), and err_idx (output, 2): the lowest mismatching index.

Function
REQ-011 SHALL implement FSM states IDLE, DRIVE, SAMPLE, CHECK and DONE.
REQ-012 IDLE with start=1 at edge E0 and valid gate_sel SHALL perform all of the following:
- latch gate_sel;
- set index=0 and {a,b}=00;
- clear tt, pass, fail, err_idx and bad_sel;
- set busy=1;
- enter DRIVE.
REQ-013 DRIVE SHALL hold {a,b} for exactly SETTLE_CYC cycles, then enter SAMPLE.
REQ-014 SAMPLE SHALL last 1 cycle and perform all of the following at its closing edge:
- write tt[index] from gate_in;
- if index<3, increment index, update {a,b} and return to DRIVE;
- if index=3, enter CHECK.
REQ-015 Index k SHALL be sampled at edge E0+(k+1)*(SETTLE_CYC+1).
REQ-016 CHECK SHALL compare tt with the expected table for the latched gate_sel. The expected values are AND=1000, OR=1110, NAND=0111, NOR=0001, XOR=0110 and XNOR=1001 (bit3..bit0).
REQ-017 The CHECK closing edge SHALL register the check result and enter DONE:
- on a match, pass=1, fail=0, err_idx=0;
- otherwise pass=0, fail=1, err_idx = lowest k where the bits differ.
REQ-018 DONE SHALL drive done=1 for one cycle. At its closing edge it SHALL return to IDLE with busy=0 and done=0.
REQ-019 With SETTLE_CYC=S, done SHALL be high in the cycle following edge E0+4S+5.
REQ-020 In IDLE, start with invalid gate_sel SHALL go directly to DONE at E0 with bad_sel=1, fail=1, pass=0, tt=0000 and no stimulus change.
REQ-021 start SHALL be ignored while busy=1. A start held high across DONE→IDLE SHALL launch a new sweep at the first IDLE edge.
REQ-022 a and b SHALL return to 00 on entering DONE.
REQ-023 tt, pass, fail, err_idx and bad_sel SHALL hold their values in IDLE until the next accepted start.
REQ-024 gate_sel changes after E0 SHALL NOT affect the running sweep.

Reset
REQ-025 rst=1 SHALL immediately, without a clock, force state IDLE, index 0, a=b=0, busy=0, done=0, tt=0000, pass=0, fail=0, bad_sel=0 and err_idx=0.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep with no done pulse. The first start after rst deasserts SHALL run a complete fresh sweep.

Structure
REQ-027 A shared package SHALL hold the gate_sel code constants, the FSM state enum, and the 4-bit expected-table constants indexed by gate code.
REQ-028 The settle counter width SHALL be 4 bits.
REQ-029 One sub-module gate_ref_lut (gate_sel in, expected tt out, valid flag) is natural. The FSM, counters and compare SHALL remain in gate_sweep_checker.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- NOR-implementing gate on gate_in, gate_sel=3, S=2, start at E0 → {a,b} steps 00,01,10,11; tt=0001; pass=1; done pulse after E0+13.
- gate_in stuck at 0, gate_sel=3 → tt=0000, fail=1, err_idx=0.
- OR gate wired, gate_sel=0 (AND) → tt=1110, fail=1, err_idx=1.
- rst pulsed while index=2 → all outputs 0 immediately, no done pulse; a following NOR sweep passes with tt=0001.
- gate_sel=6 → done high in the cycle after E0; bad_sel=1, fail=1, a=b=0 throughout.
- second start pulse during busy → ignored; exactly one done pulse; results unchanged.
